debounce: RTL and testbench
===========================

Name: debounce

Overview:
Filters a mechanical push-button or switch input into a clean, glitch-free level and one-cycle edge pulses. The raw asynchronous input is first synchronized into the i_clk domain. A change is accepted only after it has been stable for DELAY consecutive clocks. The block sits between board-level buttons and control logic, for example the camera config/reset trigger. At 100 MHz, the default DELAY gives a 10 ms debounce time.

Parameters:
DELAY, 1_000_000, number of consecutive stable clocks required before the output follows the input; debounce time = DELAY / f_clk; legal range is DELAY >= 1.
SYNC_STAGES, 2, depth of the input synchronizer flop chain; legal range is SYNC_STAGES >= 2.

Ports:
i_clk  input  1  system clock; all logic is on the rising edge.
i_rstn  input  1  synchronous active-low reset.
i_btn_in  input  1  raw, asynchronous, possibly bouncing button level.
o_btn_db  output  1  debounced button level, registered.
o_btn_rise  output  1  one-clock pulse when o_btn_db goes 0->1, registered.
o_btn_fall  output  1  one-clock pulse when o_btn_db goes 1->0, registered.

Behaviour:
- Interface: one clock, i_clk; reset i_rstn is synchronous and active-low; the polarity and synchronicity are fixed.
- Reset: while i_rstn=0 at a rising edge, all of the following clear to 0:
  - the synchronizer flops;
  - the counter;
  - o_btn_db, o_btn_rise and o_btn_fall.
- Reset has priority over all other logic, including an in-progress count. After reset, a held-high input needs the full latency again.
- Synchronizer: i_btn_in passes through SYNC_STAGES flops. The last stage, btn_sync, is the only value the filter uses.
- Counter: width is clog2(DELAY+1) bits and it saturates, never wrapping. Each edge, in priority order:
  - If btn_sync == o_btn_db: counter <= 0.
  - Else if counter == DELAY-1: o_btn_db <= btn_sync and counter <= 0.
  - Else: counter <= counter + 1.
- Consequence: a differing level must be present on btn_sync for exactly DELAY consecutive edges before o_btn_db changes.
  - Any return to the current output level in between restarts the count from 0.
  - A pulse or glitch shorter than DELAY clocks (after synchronization) never reaches o_btn_db.
- Latency: the raw input changes and stays stable. o_btn_db changes SYNC_STAGES + DELAY rising edges after the first edge that samples the new raw level. With defaults that is 1_000_002 clocks.
- DELAY=1: the output follows btn_sync with one register of delay; there is no filtering beyond the synchronizer.
- Edge pulses:
  - o_btn_rise is asserted for exactly the one cycle in which o_btn_db has just become 1.
  - o_btn_fall is asserted for exactly the one cycle in which o_btn_db has just become 0.
  - Both pulses are registered on the same edge that updates o_btn_db; they are never both high.
- Outputs are glitch-free registers. There is no combinational path from i_btn_in to any output.

Test Plan:
1. Reset: hold i_rstn=0 for 2 clocks with i_btn_in=1, then release.
   - Required: o_btn_db=0, rise=0, fall=0 during reset.
   - Required: o_btn_db rises exactly SYNC_STAGES+DELAY clocks after release.
2. Glitch filter: DELAY=1_000_000 (100 MHz). Toggle i_btn_in 20 times at random intervals, each shorter than DELAY clocks.
   - Required: o_btn_db never changes from 0; rise/fall never pulse.
3. Clean press: hold i_btn_in=1 for DELAY+1 clocks beyond the synchronizer.
   - Required: o_btn_db=1 at exactly SYNC_STAGES+DELAY edges.
   - Required: o_btn_rise high for 1 cycle at that edge.
   - Then toggle and hold 0 for DELAY+1 clocks. Required: o_btn_db=0 with a single o_btn_fall pulse.
4. Boundary: DELAY=16. Apply a high pulse of 16 clocks, then one of 17 clocks.
   - Required: the 16-clock pulse still produces an output change (count reaches DELAY).
   - Required: a 15-clock pulse produces no change.
   - Required: the counter restarts after the input returns to the output level.
5. Reset mid-count: DELAY=16. Hold input 1; assert i_rstn=0 for 1 clock at count 10.
   - Required: o_btn_db stays 0 and the count restarts.
   - Required: the output rises SYNC_STAGES+16 clocks after reset release.

Source files
------------

// File: rtl/debounce.sv
// rtl/debounce.sv - button/switch debouncer: input synchronizer, stability counter, registered level and edge pulses
module debounce #(
    parameter int DELAY       = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_btn_in,
    output logic o_btn_db,
    output logic o_btn_rise,
    output logic o_btn_fall
);

    localparam int             CW   = $clog2(DELAY + 1);
    localparam logic [CW-1:0]  LAST = CW'(DELAY - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   w_btn_sync;
    logic                   w_differs;
    logic                   w_expire;

    assign w_btn_sync = r_sync[SYNC_STAGES-1];
    assign w_differs  = w_btn_sync ^ o_btn_db;
    assign w_expire   = w_differs && (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_in};
        end
    end

    // Count consecutive clocks on which the synchronized level differs from
    // the output; any agreement restarts the count.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_cnt <= '0;
        end else if (!w_differs || w_expire) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_btn_db   <= 1'b0;
            o_btn_rise <= 1'b0;
            o_btn_fall <= 1'b0;
        end else begin
            o_btn_rise <= w_expire & w_btn_sync;
            o_btn_fall <= w_expire & ~w_btn_sync;
            if (w_expire) begin
                o_btn_db <= w_btn_sync;
            end
        end
    end

endmodule

// File: tb/tb_debounce.sv
// tb/tb_debounce.sv - scoreboard bench for debounce at DELAY=16, default DELAY and DELAY=1
module tb_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    logic in16, inbig, in1;
    logic db16, r16, f16;
    logic dbb, rb, fb;
    logic db1, r1, f1;

    debounce #(.DELAY(16), .SYNC_STAGES(2)) u_d16 (
        .i_clk(clk), .i_rstn(rstn), .i_btn_in(in16),
        .o_btn_db(db16), .o_btn_rise(r16), .o_btn_fall(f16)
    );

    debounce u_dbig (
        .i_clk(clk), .i_rstn(rstn), .i_btn_in(inbig),
        .o_btn_db(dbb), .o_btn_rise(rb), .o_btn_fall(fb)
    );

    debounce #(.DELAY(1), .SYNC_STAGES(2)) u_d1 (
        .i_clk(clk), .i_rstn(rstn), .i_btn_in(in1),
        .o_btn_db(db1), .o_btn_rise(r1), .o_btn_fall(f1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         dly[3] = '{16, 1000000, 1};
    logic [1:0] m_sync[3];
    int         m_cnt[3];
    logic       m_db[3], m_r[3], m_f[3];

    int nrise[3], nfall[3], last_rise[3], last_fall[3];

    logic [8:0] exp_q[$];

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int id, input logic in, input logic rn);
        logic bs;
        if (!rn) begin
            m_sync[id] = 2'b00;
            m_cnt[id]  = 0;
            m_db[id]   = 1'b0;
            m_r[id]    = 1'b0;
            m_f[id]    = 1'b0;
        end else begin
            bs         = m_sync[id][1];
            m_sync[id] = {m_sync[id][0], in};
            m_r[id]    = 1'b0;
            m_f[id]    = 1'b0;
            if (bs == m_db[id]) begin
                m_cnt[id] = 0;
            end else if (m_cnt[id] == dly[id] - 1) begin
                m_db[id]  = bs;
                m_r[id]   = bs;
                m_f[id]   = ~bs;
                m_cnt[id] = 0;
            end else begin
                m_cnt[id]++;
            end
        end
    endtask

    task automatic step(input logic a, input logic b, input logic c, input logic rn);
        logic [8:0] e;
        logic [2:0] got[3];
        in16  = a;
        inbig = b;
        in1   = c;
        rstn  = rn;
        model_step(0, a, rn);
        model_step(1, b, rn);
        model_step(2, c, rn);
        exp_q.push_back({m_db[0], m_r[0], m_f[0], m_db[1], m_r[1], m_f[1], m_db[2], m_r[2], m_f[2]});
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("queue_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check("out_d16",  int'({db16, r16, f16}), int'(e[8:6]));
            check("out_dbig", int'({dbb, rb, fb}),    int'(e[5:3]));
            check("out_d1",   int'({db1, r1, f1}),    int'(e[2:0]));
        end
        got[0] = {db16, r16, f16};
        got[1] = {dbb, rb, fb};
        got[2] = {db1, r1, f1};
        for (int i = 0; i < 3; i++) begin
            if (got[i][1]) begin nrise[i]++; last_rise[i] = cyc; end
            if (got[i][0]) begin nfall[i]++; last_fall[i] = cyc; end
        end
    endtask

    task automatic hold(input logic a, input logic b, input logic c, input int n);
        for (int i = 0; i < n; i++) step(a, b, c, 1'b1);
    endtask

    initial begin
        int s, nr, nf, ivl;
        logic g;
        for (int i = 0; i < 3; i++) begin
            m_sync[i] = 2'b00; m_cnt[i] = 0; m_db[i] = 0; m_r[i] = 0; m_f[i] = 0;
            nrise[i] = 0; nfall[i] = 0; last_rise[i] = -1; last_fall[i] = -1;
        end
        in16 = 1'b1; inbig = 1'b0; in1 = 1'b1; rstn = 1'b0;

        // Reset with input high, then measure rise latency after release
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("rst_db16", int'({db16, r16, f16}), 0);
        check("rst_db1",  int'({db1, r1, f1}),    0);
        s = cyc;
        hold(1'b1, 1'b0, 1'b1, 40);
        check("rst_lat16", last_rise[0] - s, 18);
        check("rst_lat1",  last_rise[1] == -1 ? last_rise[2] - s : -1, 3);
        check("rst_db16_hi", int'(db16), 1);

        // Glitches on the default-DELAY instance, all far shorter than DELAY
        g = 1'b0;
        for (int t = 0; t < 20; t++) begin
            g   = ~g;
            ivl = int'($urandom_range(1, 150));
            hold(1'b1, g, 1'b1, ivl);
        end
        check("glitch_db",   int'(dbb), 0);
        check("glitch_rise", nrise[1], 0);
        check("glitch_fall", nfall[1], 0);

        // Clean release then clean press on DELAY=16 and DELAY=1
        nf = nfall[0];
        s  = cyc;
        hold(1'b0, 1'b0, 1'b0, 40);
        check("fall_lat16", last_fall[0] - s, 18);
        check("fall_cnt16", nfall[0] - nf, 1);
        check("fall_lat1",  last_fall[2] - s, 3);
        nr = nrise[0];
        s  = cyc;
        hold(1'b1, 1'b0, 1'b1, 40);
        check("rise_lat16", last_rise[0] - s, 18);
        check("rise_cnt16", nrise[0] - nr, 1);
        check("rise_lat1",  last_rise[2] - s, 3);
        hold(1'b0, 1'b0, 1'b0, 40);

        // Pulse-width boundary around DELAY=16
        nr = nrise[0];
        nf = nfall[0];
        hold(1'b1, 1'b0, 1'b0, 15);
        hold(1'b0, 1'b0, 1'b0, 30);
        check("pulse15", nrise[0] - nr, 0);
        hold(1'b1, 1'b0, 1'b0, 16);
        hold(1'b0, 1'b0, 1'b0, 30);
        check("pulse16_rise", nrise[0] - nr, 1);
        check("pulse16_fall", nfall[0] - nf, 1);
        hold(1'b1, 1'b0, 1'b0, 17);
        hold(1'b0, 1'b0, 1'b0, 30);
        check("pulse17", nrise[0] - nr, 2);
        hold(1'b1, 1'b0, 1'b0, 10);
        hold(1'b0, 1'b0, 1'b0, 1);
        hold(1'b1, 1'b0, 1'b0, 10);
        hold(1'b0, 1'b0, 1'b0, 30);
        check("restart", nrise[0] - nr, 2);

        // Reset while the counter sits at 10
        nr = nrise[0];
        hold(1'b1, 1'b0, 1'b0, 12);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_mid_db", int'(db16), 0);
        s = cyc;
        hold(1'b1, 1'b0, 1'b0, 40);
        check("rst_mid_cnt", nrise[0] - nr, 1);
        check("rst_mid_lat", last_rise[0] - s, 18);

        // DELAY=1 passes a single-clock pulse straight through
        hold(1'b0, 1'b0, 1'b0, 5);
        nr = nrise[2];
        nf = nfall[2];
        step(1'b0, 1'b0, 1'b1, 1'b1);
        hold(1'b0, 1'b0, 1'b0, 10);
        check("d1_pulse_rise", nrise[2] - nr, 1);
        check("d1_pulse_fall", nfall[2] - nf, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
